// File: rtl/switch_pkg.sv
// Shared types for the switch core's MAC learning/forwarding path.
//   mac_address_t      : 48-bit MAC address
//   mac_table_entry_t  : one table slot {valid, mac, port, age}; port/age use
//                        fixed 8-bit fields so the struct is parameter-independent
//   forwarding_state_t : lookup engine FSM states
//   is_group_address() : I/G bit (bit 40) of a MAC address
package switch_pkg;

  localparam int ENTRY_PORT_BITS = 8;
  localparam int ENTRY_AGE_BITS  = 8;

  typedef logic [47:0] mac_address_t;

  typedef struct packed {
    logic                      valid;
    mac_address_t              mac;
    logic [ENTRY_PORT_BITS-1:0] port;
    logic [ENTRY_AGE_BITS-1:0]  age;
  } mac_table_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    LEARN,
    RESPOND
  } forwarding_state_t;

  function automatic logic is_group_address(input mac_address_t address);
    return address[40];
  endfunction

endpackage

// File: rtl/mac_table_storage.sv
// MAC table register array with aging, flush and a single write port.
//   clock, reset     : core clock, synchronous active-high reset
//   age_tick         : increment age of every valid entry (saturating); entries
//                      reaching AGE_LIMIT are invalidated in the same cycle
//   flush            : invalidate every entry (beats write and age_tick)
//   write_enable/index/entry : learn write; beats age_tick on the same entry
//   read_index/read_entry    : combinational read port driven by the search pointer
//   valid_count      : registered count of valid entries (one cycle behind the table)
module mac_table_storage
  import switch_pkg::*;
#(
  parameter int TABLE_DEPTH = 16,
  parameter int AGE_WIDTH   = 4,
  parameter int AGE_LIMIT   = 15
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           age_tick,
  input  logic                           flush,
  input  logic                           write_enable,
  input  logic [$clog2(TABLE_DEPTH)-1:0] write_index,
  input  mac_table_entry_t               write_entry,
  input  logic [$clog2(TABLE_DEPTH)-1:0] read_index,
  output mac_table_entry_t               read_entry,
  output logic [$clog2(TABLE_DEPTH):0]   valid_count
);

  localparam int INDEX_WIDTH = $clog2(TABLE_DEPTH);
  localparam int COUNT_WIDTH = INDEX_WIDTH + 1;
  localparam logic [ENTRY_AGE_BITS-1:0] AGE_MAX    = ENTRY_AGE_BITS'((1 << AGE_WIDTH) - 1);
  localparam logic [ENTRY_AGE_BITS-1:0] AGE_EXPIRE = ENTRY_AGE_BITS'(AGE_LIMIT);

  mac_table_entry_t          entries_q    [TABLE_DEPTH];
  mac_table_entry_t          entries_next [TABLE_DEPTH];
  logic [COUNT_WIDTH-1:0]    count_next;

  always_comb begin
    for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
      entries_next[i] = entries_q[i];
      if (flush) begin
        entries_next[i].valid = 1'b0;
        entries_next[i].age   = '0;
      end else if (write_enable && write_index == INDEX_WIDTH'(i)) begin
        entries_next[i] = write_entry;
      end else if (age_tick && entries_q[i].valid) begin
        if (entries_q[i].age != AGE_MAX)
          entries_next[i].age = entries_q[i].age + 1'b1;
        if (entries_next[i].age >= AGE_EXPIRE)
          entries_next[i].valid = 1'b0;
      end
    end
  end

  always_comb begin
    count_next = '0;
    for (int unsigned i = 0; i < TABLE_DEPTH; i++)
      count_next = count_next + COUNT_WIDTH'(entries_q[i].valid);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < TABLE_DEPTH; i++)
        entries_q[i] <= '0;
      valid_count <= '0;
    end else begin
      for (int unsigned i = 0; i < TABLE_DEPTH; i++)
        entries_q[i] <= entries_next[i];
      valid_count <= count_next;
    end
  end

  assign read_entry = entries_q[read_index];

endmodule

// File: rtl/mac_forwarding_engine.sv
// Learning/forwarding engine: accepts one header per request, scans the MAC
// table one entry per cycle, learns src->port, and returns an egress port mask
// exactly TABLE_DEPTH+2 cycles after the accepting edge.
//   clock, reset                      : core clock, synchronous active-high reset
//   lookup_valid/lookup_ready         : request handshake (ready only in IDLE)
//   lookup_destination_mac/source_mac : frame header MACs
//   lookup_source_port                : ingress port index
//   result_valid                      : one-cycle result pulse
//   result_port_mask/result_hit       : egress mask, destination found
//   age_tick, flush                   : table aging strobe, whole-table invalidate
//   table_occupancy                   : count of valid entries
module mac_forwarding_engine
  import switch_pkg::*;
#(
  parameter int NUMBER_OF_PORTS = 4,
  parameter int TABLE_DEPTH     = 16,
  parameter int AGE_WIDTH       = 4,
  parameter int AGE_LIMIT       = 15
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               lookup_valid,
  output logic                               lookup_ready,
  input  logic [47:0]                        lookup_destination_mac,
  input  logic [47:0]                        lookup_source_mac,
  input  logic [$clog2(NUMBER_OF_PORTS)-1:0] lookup_source_port,
  output logic                               result_valid,
  output logic [NUMBER_OF_PORTS-1:0]         result_port_mask,
  output logic                               result_hit,
  input  logic                               age_tick,
  input  logic                               flush,
  output logic [$clog2(TABLE_DEPTH):0]       table_occupancy
);

  localparam int PORT_WIDTH  = $clog2(NUMBER_OF_PORTS);
  localparam int INDEX_WIDTH = $clog2(TABLE_DEPTH);

  forwarding_state_t state_q, state_next;

  mac_address_t                dst_q, src_q;
  logic [PORT_WIDTH-1:0]       port_q;
  logic [INDEX_WIDTH-1:0]      ptr_q;
  logic                        dst_hit_q, src_hit_q, free_found_q, flushed_q;
  logic [ENTRY_PORT_BITS-1:0]  dst_port_q;
  logic [INDEX_WIDTH-1:0]      src_index_q, free_index_q, victim_index_q;
  logic [ENTRY_AGE_BITS-1:0]   victim_age_q;

  logic                        write_enable;
  logic [INDEX_WIDTH-1:0]      write_index;
  mac_table_entry_t            write_entry;
  mac_table_entry_t            read_entry;
  logic [NUMBER_OF_PORTS-1:0]  flood_mask;

  mac_table_storage #(
    .TABLE_DEPTH (TABLE_DEPTH),
    .AGE_WIDTH   (AGE_WIDTH),
    .AGE_LIMIT   (AGE_LIMIT)
  ) u_storage (
    .clock        (clock),
    .reset        (reset),
    .age_tick     (age_tick),
    .flush        (flush),
    .write_enable (write_enable),
    .write_index  (write_index),
    .write_entry  (write_entry),
    .read_index   (ptr_q),
    .read_entry   (read_entry),
    .valid_count  (table_occupancy)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_next;
  end

  always_comb begin
    state_next   = state_q;
    lookup_ready = 1'b0;
    write_enable = 1'b0;
    write_index  = victim_index_q;
    write_entry  = '{valid: 1'b1, mac: src_q, port: ENTRY_PORT_BITS'(port_q), age: '0};
    flood_mask   = ~(NUMBER_OF_PORTS'(1) << port_q);
    if (src_hit_q)         write_index = src_index_q;
    else if (free_found_q) write_index = free_index_q;
    case (state_q)
      IDLE: begin
        lookup_ready = 1'b1;
        if (lookup_valid) state_next = SEARCH;
      end
      SEARCH: if (ptr_q == INDEX_WIDTH'(TABLE_DEPTH - 1)) state_next = LEARN;
      LEARN: begin
        write_enable = !flushed_q && !is_group_address(src_q) && (src_q != '0);
        state_next   = RESPOND;
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Search bookkeeping: dst/src matches, first free slot, and the oldest entry
  // (strictly-greater compare keeps the lowest index on age ties).
  always_ff @(posedge clock) begin
    if (reset) begin
      dst_q <= '0; src_q <= '0; port_q <= '0; ptr_q <= '0;
      dst_hit_q <= 1'b0; src_hit_q <= 1'b0; free_found_q <= 1'b0; flushed_q <= 1'b0;
      dst_port_q <= '0; src_index_q <= '0; free_index_q <= '0;
      victim_index_q <= '0; victim_age_q <= '0;
      result_valid <= 1'b0; result_port_mask <= '0; result_hit <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state_q)
        IDLE: if (lookup_valid) begin
          dst_q <= lookup_destination_mac;
          src_q <= lookup_source_mac;
          port_q <= lookup_source_port;
          ptr_q <= '0;
          dst_hit_q <= 1'b0; src_hit_q <= 1'b0; free_found_q <= 1'b0;
          victim_index_q <= '0; victim_age_q <= '0;
          flushed_q <= flush;
        end
        SEARCH: begin
          ptr_q <= ptr_q + 1'b1;
          if (flush) flushed_q <= 1'b1;
          if (read_entry.valid) begin
            if (read_entry.mac == dst_q && !dst_hit_q) begin
              dst_hit_q  <= 1'b1;
              dst_port_q <= read_entry.port;
            end
            if (read_entry.mac == src_q && !src_hit_q) begin
              src_hit_q   <= 1'b1;
              src_index_q <= ptr_q;
            end
            if (read_entry.age > victim_age_q) begin
              victim_index_q <= ptr_q;
              victim_age_q   <= read_entry.age;
            end
          end else if (!free_found_q) begin
            free_found_q <= 1'b1;
            free_index_q <= ptr_q;
          end
        end
        LEARN: if (flush) flushed_q <= 1'b1;
        RESPOND: begin
          result_valid <= 1'b1;
          if (flushed_q || flush || is_group_address(dst_q) || !dst_hit_q) begin
            result_port_mask <= flood_mask;
            result_hit       <= 1'b0;
          end else begin
            result_hit <= 1'b1;
            if (dst_port_q == ENTRY_PORT_BITS'(port_q)) result_port_mask <= '0;
            else result_port_mask <= NUMBER_OF_PORTS'(1) << dst_port_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_forwarding_engine.sv
// Scoreboard bench for mac_forwarding_engine: a table-level reference model
// predicts each result when the request is issued; a monitor pops and compares
// on every result_valid pulse, including the accept-to-result latency.
module tb_mac_forwarding_engine;

  localparam int NP    = 4;
  localparam int DEPTH = 16;
  localparam int LIMIT = 15;
  localparam int LAT   = DEPTH + 2;

  logic        clock = 1'b0;
  logic        reset, lookup_valid, lookup_ready, age_tick, flush;
  logic [47:0] lookup_destination_mac, lookup_source_mac;
  logic [1:0]  lookup_source_port;
  logic        result_valid, result_hit;
  logic [3:0]  result_port_mask;
  logic [4:0]  table_occupancy;

  mac_forwarding_engine #(
    .NUMBER_OF_PORTS (NP),
    .TABLE_DEPTH     (DEPTH),
    .AGE_WIDTH       (4),
    .AGE_LIMIT       (LIMIT)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .lookup_valid           (lookup_valid),
    .lookup_ready           (lookup_ready),
    .lookup_destination_mac (lookup_destination_mac),
    .lookup_source_mac      (lookup_source_mac),
    .lookup_source_port     (lookup_source_port),
    .result_valid           (result_valid),
    .result_port_mask       (result_port_mask),
    .result_hit             (result_hit),
    .age_tick               (age_tick),
    .flush                  (flush),
    .table_occupancy        (table_occupancy)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  mask;
    logic        hit;
    int unsigned cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference table: a plain array of stations.
  bit          mv[DEPTH];
  logic [47:0] mm[DEPTH];
  int          mp[DEPTH];
  int          ma[DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] flood(input int p);
    logic [3:0] one = 4'b0001;
    return 4'hF & ~(one << p);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
  endfunction

  function automatic int model_occ();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(mv[i]);
    return n;
  endfunction

  function automatic void model_tick();
    for (int i = 0; i < DEPTH; i++)
      if (mv[i]) begin
        ma[i]++;
        if (ma[i] >= LIMIT) mv[i] = 1'b0;
      end
  endfunction

  // Forwarding decision on the table as it stands, then learn the source.
  function automatic void model_req(input logic [47:0] d, input logic [47:0] s, input int p,
                                    output logic [3:0] m, output logic h);
    int f = -1;
    int k = -1;
    logic [3:0] one = 4'b0001;
    for (int i = 0; i < DEPTH; i++) if (f < 0 && mv[i] && mm[i] == d) f = i;
    if (d[40] || f < 0) begin
      m = flood(p); h = 1'b0;
    end else begin
      h = 1'b1;
      m = (mp[f] == p) ? 4'b0000 : (one << mp[f]);
    end
    if (!s[40] && s != 48'd0) begin
      for (int i = 0; i < DEPTH; i++) if (k < 0 && mv[i] && mm[i] == s) k = i;
      for (int i = 0; i < DEPTH; i++) if (k < 0 && !mv[i]) k = i;
      if (k < 0) begin
        k = 0;
        for (int i = 1; i < DEPTH; i++) if (ma[i] > ma[k]) k = i;
      end
      mv[k] = 1'b1; mm[k] = s; mp[k] = p; ma[k] = 0;
    end
  endfunction

  // Monitor: any result pulse must match the oldest outstanding prediction.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && result_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result actual mask=%b required no pulse", result_port_mask);
      end else begin
        e = exp_q.pop_front();
        check("mask", 64'(result_port_mask), 64'(e.mask));
        check("hit", 64'(result_hit), 64'(e.hit));
        check("latency", 64'(cyc - e.cyc), 64'(LAT));
      end
    end
  end

  task automatic do_req(input logic [47:0] dmac, input logic [47:0] smac, input int p,
                        input bit flush_mid, input bit reset_mid);
    int n;
    exp_t e;
    logic [3:0] m;
    logic h;
    n = 0;
    while (!lookup_ready && n < 50) begin @(negedge clock); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL ready_timeout actual=0 required=1"); end
    if (flush_mid) begin
      m = flood(p); h = 1'b0; model_clear();
    end else if (!reset_mid) begin
      model_req(dmac, smac, p, m, h);
    end
    lookup_destination_mac = dmac;
    lookup_source_mac      = smac;
    lookup_source_port     = 2'(p);
    lookup_valid           = 1'b1;
    @(posedge clock);
    #1;
    lookup_valid = 1'b0;
    if (!reset_mid) begin
      e.mask = m; e.hit = h; e.cyc = cyc;
      exp_q.push_back(e);
    end
    if (flush_mid || reset_mid) begin
      repeat (4) @(negedge clock);
      if (flush_mid) flush = 1'b1; else reset = 1'b1;
      @(negedge clock);
      flush = 1'b0; reset = 1'b0;
      if (reset_mid) model_clear();
    end
    if (reset_mid) begin
      repeat (25) @(negedge clock);
    end else begin
      n = 0;
      @(negedge clock);
      while (!lookup_ready && n < 40) begin @(negedge clock); n++; end
      if (n >= 40) begin checks++; errors++; $display("FAIL result_timeout actual=busy required=idle"); end
    end
    @(negedge clock);
  endtask

  task automatic tick();
    @(negedge clock);
    age_tick = 1'b1;
    @(negedge clock);
    age_tick = 1'b0;
    model_tick();
  endtask

  task automatic check_occ(input string name);
    @(negedge clock);
    check(name, 64'(table_occupancy), 64'(model_occ()));
  endtask

  // 0xBB has the I/G bit set, so unicast test stations use 0xBC/0xCC prefixes.
  localparam logic [47:0] MAC_A  = 48'hAA00_0000_0001;
  localparam logic [47:0] MAC_B  = 48'hBC00_0000_0002;
  localparam logic [47:0] MAC_C  = 48'hCC00_0000_0003;
  localparam logic [47:0] MAC_D  = 48'h0200_0000_0004;
  localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;

  logic [47:0] pool[8];
  logic [47:0] old5, d, s;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; lookup_valid = 1'b0; age_tick = 1'b0; flush = 1'b0;
    lookup_destination_mac = '0; lookup_source_mac = '0; lookup_source_port = '0;
    model_clear();
    for (int i = 0; i < 8; i++) begin
      pool[i] = {16'($urandom), 32'($urandom)};
      pool[i][40] = 1'b0;
      pool[i][0]  = 1'b1;
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_ready", 64'(lookup_ready), 64'd1);
    check("reset_valid", 64'(result_valid), 64'd0);
    check("reset_mask", 64'(result_port_mask), 64'd0);
    check("reset_hit", 64'(result_hit), 64'd0);
    check("reset_occ", 64'(table_occupancy), 64'd0);

    // Miss floods, then learned source is found.
    do_req(MAC_A, MAC_B, 1, 0, 0);
    check("occ_after_first", 64'(table_occupancy), 64'd1);
    do_req(MAC_B, MAC_C, 3, 0, 0);
    check("occ_after_second", 64'(table_occupancy), 64'd2);
    // Broadcast flood, then same-port filtering.
    do_req(BCAST, MAC_D, 0, 0, 0);
    do_req(MAC_D, MAC_A, 0, 0, 0);
    // Station move.
    do_req(MAC_C, MAC_B, 2, 0, 0);
    do_req(MAC_B, 48'd0, 0, 0, 0);
    check_occ("occ_directed");

    // Full table replacement of the oldest entry, then age everything out.
    @(negedge clock); flush = 1'b1; @(negedge clock); flush = 1'b0; model_clear();
    check_occ("occ_after_flush");
    for (int i = 1; i <= DEPTH; i++) do_req(MAC_A, {40'h02_0000_0000, 8'(i)}, i % NP, 0, 0);
    check_occ("occ_full");
    repeat (3) tick();
    for (int i = 1; i <= DEPTH; i++) if (i != 6) do_req(BCAST, {40'h02_0000_0000, 8'(i)}, i % NP, 0, 0);
    old5 = mm[5];
    do_req(BCAST, MAC_C, 3, 0, 0);
    do_req(old5, 48'd0, 0, 0, 0);
    do_req(MAC_C, 48'd0, 1, 0, 0);
    check_occ("occ_full_after_replace");
    repeat (LIMIT) tick();
    check_occ("occ_aged_out");

    // Randomised traffic over a small station pool.
    for (int r = 0; r < 60; r++) begin
      int sel;
      sel = $urandom_range(0, 9);
      d = pool[$urandom_range(0, 7)];
      s = pool[$urandom_range(0, 7)];
      if (sel == 0) d = BCAST;
      if (sel == 1) d[40] = 1'b1;
      if (sel == 2) s = 48'd0;
      if (sel == 3) s[40] = 1'b1;
      do_req(d, s, $urandom_range(0, 3), 0, 0);
      if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, 4)) tick();
      if (r % 10 == 9) check_occ("occ_random");
    end

    // Flush mid-search: flood result, nothing learned.
    do_req(MAC_A, MAC_D, 2, 1, 0);
    check_occ("occ_flush_mid");
    do_req(MAC_D, 48'd0, 1, 0, 0);
    // Reset mid-search: no result pulse, engine idle and empty.
    do_req(MAC_B, MAC_C, 0, 0, 1);
    check("ready_after_reset", 64'(lookup_ready), 64'd1);
    check("occ_after_reset", 64'(table_occupancy), 64'd0);
    do_req(MAC_C, 48'd0, 3, 0, 0);

    repeat (5) @(negedge clock);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
